// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with a byte-strobed register file, programmable wait states and range-check error
module apb_slave_regfile #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    prst,
    input  logic                    psel,
    input  logic                    pen,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   o_prdata,
    output logic                    o_pready,
    output logic                    o_pslverr
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         strb_q, strb_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  setup, hold, err, go, commit;

    // Next state: latch request at setup, count wait states, respond on READY entry, commit write on READY exit
    always_comb begin
        setup     = state_q == S_IDLE && psel && !pen;
        hold      = state_q == S_WAIT && psel && pen;
        addr_d    = setup ? paddr : addr_q;
        write_d   = setup ? pwrite : write_q;
        wdata_d   = setup ? pwdata : wdata_q;
        strb_d    = setup ? pstrb : strb_q;
        err       = {1'b0, addr_d} >= DEPTH_W;
        go        = (setup && WS == 4'd0) || (hold && cnt_q == 4'd1);
        state_d   = go ? S_READY : (setup || hold) ? S_WAIT : S_IDLE;
        cnt_d     = setup ? WS : hold ? cnt_q - 4'd1 : cnt_q;
        pready_d  = go;
        pslverr_d = go && err;
        prdata_d  = (go && !write_d && !err) ? mem_q[addr_d[IW-1:0]] : '0;
        commit    = state_q == S_READY && psel && write_q && !pslverr_q;
        mem_d     = mem_q;
        for (int i = 0; i < SW; i++)
            if (commit && strb_q[i]) mem_d[addr_q[IW-1:0]][8*i +: 8] = wdata_q[8*i +: 8];
    end

    // State and storage registers with synchronous reset clearing the whole file
    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            mem_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            mem_q     <= mem_d;
        end
    end

    assign o_prdata  = prdata_q;
    assign o_pready  = pready_q;
    assign o_pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: directed checks of a zero-wait and a two-wait-state instance
module tb_apb_slave_regfile;
    logic        pclk = 1'b0;
    logic        prst = 1'b0;
    logic        psel = 1'b0;
    logic        pen = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    int          dsel = 0;
    logic        psel0, psel2;
    logic [31:0] prdata0, prdata2;
    logic        pready0, pready2, pslverr0, pslverr2;
    int          checks = 0;
    int          failures = 0;

    assign psel0 = psel && dsel == 0;
    assign psel2 = psel && dsel == 2;

    always #5 pclk = ~pclk;

    apb_slave_regfile #(.WAIT_STATES(0)) u0 (
        .pclk(pclk), .prst(prst), .psel(psel0), .pen(pen), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .o_prdata(prdata0), .o_pready(pready0), .o_pslverr(pslverr0)
    );

    apb_slave_regfile #(.WAIT_STATES(2)) u2 (
        .pclk(pclk), .prst(prst), .psel(psel2), .pen(pen), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .o_prdata(prdata2), .o_pready(pready2), .o_pslverr(pslverr2)
    );

    // One transfer: setup cycle, then access until pready; leaves psel high so a following call is back-to-back
    task automatic apb(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic err, output int lat);
        @(posedge pclk); #1;
        dsel = d; psel = 1'b1; pen = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
        @(posedge pclk); #1;
        pen = 1'b1;
        lat = 1;
        while (!(d == 0 ? pready0 : pready2) && lat < 20) begin
            @(posedge pclk); #1;
            lat++;
        end
        rd  = d == 0 ? prdata0 : prdata2;
        err = d == 0 ? pslverr0 : pslverr2;
        if (lat >= 20) begin
            checks++; failures++;
            $display("FAIL timeout addr=%0d: pready not seen within %0d cycles", a, lat);
        end
    endtask

    task automatic idle();
        @(posedge pclk); #1;
        psel = 1'b0; pen = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic err; int lat;
        prst = 1'b1;
        repeat (2) @(posedge pclk);
        #1 prst = 1'b0;
        checks++; if (pready0 !== 1'b0 || pready2 !== 1'b0) begin failures++; $display("FAIL reset_pready got=%b/%b exp=0", pready0, pready2); end
        checks++; if (pslverr0 !== 1'b0 || pslverr2 !== 1'b0) begin failures++; $display("FAIL reset_pslverr got=%b/%b exp=0", pslverr0, pslverr2); end
        checks++; if (prdata0 !== 32'h0 || prdata2 !== 32'h0) begin failures++; $display("FAIL reset_prdata got=%h/%h exp=0", prdata0, prdata2); end
        apb(0, 1'b0, 32'd5, 32'h0, 4'h0, rd, err, lat);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_read5 got=%h exp=00000000", rd); end
        idle();
    endtask

    task automatic test_ws0();
        logic [31:0] rd; logic err; int lat;
        apb(0, 1'b1, 32'd31, 32'hDEADBEEF, 4'hF, rd, err, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL ws0_wr_latency got=%0d exp=1", lat); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL ws0_wr_err got=%b exp=0", err); end
        apb(0, 1'b0, 32'd31, 32'h0, 4'h0, rd, err, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL ws0_rd_latency got=%0d exp=1", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL ws0_rd_data got=%h exp=deadbeef", rd); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL ws0_rd_err got=%b exp=0", err); end
        idle();
    endtask

    task automatic test_ws2();
        logic [31:0] rd; logic err; int lat;
        apb(2, 1'b1, 32'd30, 32'h12345678, 4'hF, rd, err, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL ws2_wr_latency got=%0d exp=3", lat); end
        apb(2, 1'b0, 32'd30, 32'h0, 4'h0, rd, err, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL ws2_rd_latency got=%0d exp=3", lat); end
        checks++; if (rd !== 32'h12345678 || err !== 1'b0) begin failures++; $display("FAIL ws2_rd_data got=%h err=%b exp=12345678 err=0", rd, err); end
        idle();
    endtask

    task automatic test_strobes();
        logic [31:0] rd; logic err; int lat;
        apb(0, 1'b1, 32'd4, 32'hFFFFFFFF, 4'hF, rd, err, lat);
        apb(0, 1'b1, 32'd4, 32'h00AA0000, 4'b0100, rd, err, lat);
        apb(0, 1'b0, 32'd4, 32'h0, 4'h0, rd, err, lat);
        checks++; if (rd !== 32'hFFAAFFFF) begin failures++; $display("FAIL strobe_merge got=%h exp=ffaaffff", rd); end
        apb(0, 1'b1, 32'd4, 32'h00000000, 4'h0, rd, err, lat);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL strobe_zero_err got=%b exp=0", err); end
        apb(0, 1'b0, 32'd4, 32'h0, 4'h0, rd, err, lat);
        checks++; if (rd !== 32'hFFAAFFFF) begin failures++; $display("FAIL strobe_zero_noop got=%h exp=ffaaffff", rd); end
        idle();
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic err; int lat;
        apb(0, 1'b1, 32'd0, 32'hA5A5A5A5, 4'hF, rd, err, lat);
        apb(0, 1'b1, 32'd32, 32'h00000055, 4'hF, rd, err, lat);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL oor_wr_err got=%b exp=1", err); end
        apb(0, 1'b0, 32'd32, 32'h0, 4'h0, rd, err, lat);
        checks++; if (err !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL oor_rd got=%h err=%b exp=00000000 err=1", rd, err); end
        apb(0, 1'b0, 32'h80000000, 32'h0, 4'h0, rd, err, lat);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL oor_high_bit_err got=%b exp=1", err); end
        apb(0, 1'b0, 32'd0, 32'h0, 4'h0, rd, err, lat);
        checks++; if (rd !== 32'hA5A5A5A5 || err !== 1'b0) begin failures++; $display("FAIL oor_no_alias got=%h err=%b exp=a5a5a5a5 err=0", rd, err); end
        idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int lat;
        logic seen;
        apb(2, 1'b1, 32'd7, 32'h00000077, 4'hF, rd, err, lat);
        @(posedge pclk); #1;
        dsel = 2; psel = 1'b1; pen = 1'b0; pwrite = 1'b1; paddr = 32'd7; pwdata = 32'h1; pstrb = 4'hF;
        @(posedge pclk); #1;
        pen = 1'b1;
        seen = pready2;
        @(posedge pclk); #1;
        psel = 1'b0; pen = 1'b0;
        seen = seen | pready2;
        for (int i = 0; i < 4; i++) begin
            @(posedge pclk); #1;
            seen = seen | pready2;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_pready got=%b exp=0", seen); end
        apb(2, 1'b0, 32'd7, 32'h0, 4'h0, rd, err, lat);
        checks++; if (rd !== 32'h00000077) begin failures++; $display("FAIL abort_no_write got=%h exp=00000077", rd); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int lat;
        logic [31:0] model [32];
        for (int a = 31; a >= 0; a--) begin
            model[a] = $urandom;
            apb(0, 1'b1, 32'(a), model[a], 4'hF, rd, err, lat);
        end
        for (int a = 31; a >= 0; a--) begin
            apb(0, 1'b0, 32'(a), 32'h0, 4'h0, rd, err, lat);
            checks++; if (rd !== model[a] || lat !== 1) begin failures++; $display("FAIL b2b_read addr=%0d got=%h lat=%0d exp=%h lat=1", a, rd, lat, model[a]); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_ws0();
        test_ws2();
        test_strobes();
        test_out_of_range();
        test_abort();
        test_back_to_back();
        repeat (2) @(posedge pclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
